// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan monitor: the legal
// segment patterns (index = hex value) and the capture FSM states.
package sseg_pkg;

  localparam int N_PATTERNS = 16;

  // seg[7:1] = {a,b,c,d,e,f,g}, dp excluded
  localparam logic [6:0] SEG_PATTERNS [N_PATTERNS] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_t;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational reverse lookup of a 7-bit segment pattern to its hex value.
// Unknown patterns report hit=0 and hex=0.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] hex,
  output logic       hit
);

  // Search the pattern table; at most one entry can match.
  always_comb begin
    hex = '0;
    hit = 1'b0;
    for (int i = 0; i < N_PATTERNS; i++) begin
      if (pattern == SEG_PATTERNS[i]) begin
        hex = 4'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sseg_scan_monitor.sv
// Multiplexed display bus monitor: recovers per-digit hex value, dp and
// validity from shared segment lines and active-low anode enables.
//
// state  | meaning
// IDLE   | not exactly one anode low; nothing to capture
// SETTLE | single anode low, counting identical {an,seg} cycles
// HOLD   | value captured; wait for the bus to change
module sseg_scan_monitor
  import sseg_pkg::*;
#(
  parameter  int N_DIGITS       = 4,
  parameter  int STABLE_CYCLES  = 8,
  parameter  int TIMEOUT_CYCLES = 100000,
  localparam int IDX_W          = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg,
  input  logic [N_DIGITS-1:0]   an,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   dps,
  output logic [N_DIGITS-1:0]   valid,
  output logic [N_DIGITS-1:0]   err,
  output logic                  upd,
  output logic [IDX_W-1:0]      upd_idx,
  output logic                  conflict
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LOW_W = $clog2(N_DIGITS + 1);

  logic [N_DIGITS-1:0] an_q, an_p;
  logic [7:0]          seg_q, seg_p;
  logic                multi_q;
  logic [LOW_W-1:0]    low_cnt;
  logic [IDX_W-1:0]    sel_idx;
  logic                one_low, multi_low, changed;
  logic [3:0]          hex;
  logic                hit;
  scan_state_t         state, state_nxt;
  logic [CNT_W-1:0]    stable_cnt, cnt_nxt;
  logic                capture;
  logic [AGE_W-1:0]    age [N_DIGITS];

  // Input register plus a one-cycle-old copy for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q    <= '1;
      seg_q   <= '0;
      an_p    <= '1;
      seg_p   <= '0;
      multi_q <= 1'b0;
    end else begin
      an_q    <= an;
      seg_q   <= seg;
      an_p    <= an_q;
      seg_p   <= seg_q;
      multi_q <= multi_low;
    end
  end

  // Count low anodes and locate the selected digit.
  always_comb begin
    low_cnt = '0;
    sel_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!an_q[i]) begin
        low_cnt = low_cnt + LOW_W'(1);
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign one_low   = (low_cnt == LOW_W'(1));
  assign multi_low = (low_cnt > LOW_W'(1));
  assign changed   = ({an_q, seg_q} != {an_p, seg_p});

  sseg_pattern_decode u_decode (
    .pattern (seg_q[7:1]),
    .hex     (hex),
    .hit     (hit)
  );

  // FSM state and debounce counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stable_cnt <= '0;
    end else begin
      state      <= state_nxt;
      stable_cnt <= cnt_nxt;
    end
  end

  // Next state; the capture fires on the cycle the count reaches its target.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = stable_cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (one_low) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      SETTLE, HOLD: begin
        if (changed) begin
          if (one_low) begin
            state_nxt = SETTLE;
            cnt_nxt   = CNT_W'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else if (state == SETTLE) begin
          cnt_nxt = stable_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (state_nxt == SETTLE && cnt_nxt == CNT_W'(STABLE_CYCLES)) begin
      capture   = 1'b1;
      state_nxt = HOLD;
    end
  end

  // Per-digit capture registers and refresh timers; capture beats expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits   <= '0;
      dps      <= '0;
      valid    <= '0;
      err      <= '0;
      upd      <= 1'b0;
      upd_idx  <= '0;
      conflict <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) age[i] <= '0;
    end else begin
      upd      <= capture;
      conflict <= multi_low && !multi_q;
      if (capture) upd_idx <= sel_idx;
      for (int i = 0; i < N_DIGITS; i++) begin
        if (capture && sel_idx == IDX_W'(i)) begin
          digits[4*i +: 4] <= hex;
          err[i]           <= !hit;
          dps[i]           <= seg_q[0];
          valid[i]         <= 1'b1;
          age[i]           <= AGE_W'(TIMEOUT_CYCLES);
        end else if (age[i] != '0) begin
          age[i] <= age[i] - AGE_W'(1);
          if (age[i] == AGE_W'(1)) valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_monitor.sv
// Scoreboard bench for sseg_scan_monitor: the driver predicts captures and
// conflict pulses from run lengths of the applied bus values; a monitor
// checks every cycle against the predictions.
module tb_sseg_scan_monitor;

  localparam int N  = 4;
  localparam int ST = 8;
  localparam int TO = 120;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  dps, valid, err;
  logic        upd;
  logic [1:0]  upd_idx;
  logic        conflict;

  sseg_scan_monitor #(.N_DIGITS(N), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an), .digits(digits), .dps(dps),
    .valid(valid), .err(err), .upd(upd), .upd_idx(upd_idx), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         due;
    int         idx;
    logic [3:0] hex;
    logic       dp;
    logic       bad;
  } cap_t;

  cap_t cap_q[$];
  int   conf_q[$];
  int   rst_q[$];

  localparam logic [7:0] HEX_BYTES [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  // driver-side model state
  int          run = 0;
  logic [11:0] prev_v = '0;
  bit          have_prev = 0;
  bit          prev_multi = 0;

  task automatic model(input int s, input logic [3:0] a, input logic [7:0] sg, input logic r);
    int   lows, id, h;
    bit   found;
    cap_t c;
    if (r) begin
      while (cap_q.size() > 0 && cap_q[$].due >= s) void'(cap_q.pop_back());
      while (conf_q.size() > 0 && conf_q[$] >= s) void'(conf_q.pop_back());
      rst_q.push_back(s);
      run = 0; have_prev = 0; prev_multi = 0;
      return;
    end
    if (have_prev && {a, sg} == prev_v) run++;
    else run = 1;
    prev_v = {a, sg};
    have_prev = 1;
    lows = 0; id = 0;
    for (int i = 0; i < N; i++) if (!a[i]) begin lows++; id = i; end
    if (lows == 1 && run == ST) begin
      found = 0; h = 0;
      for (int i = 0; i < 16; i++) if ((sg & 8'hFE) == HEX_BYTES[i]) begin found = 1; h = i; end
      c.due = s + 1; c.idx = id; c.hex = 4'(h); c.dp = sg[0]; c.bad = !found;
      cap_q.push_back(c);
    end
    if (lows > 1 && !prev_multi) conf_q.push_back(s + 1);
    prev_multi = (lows > 1);
  endtask

  task automatic slot(input logic [3:0] a, input logic [7:0] sg, input logic r);
    @(posedge clk);
    #1;
    an = a; seg = sg; rst = r;
    model(cyc + 1, a, sg, r);
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] sg, input int n);
    repeat (n) slot(a, sg, 1'b0);
  endtask

  // monitor-side expected output state
  logic [3:0] m_hex [4];
  logic [3:0] m_dp, m_err, m_valid;
  int         m_cap [4];

  task automatic check_cycle();
    logic [15:0] exp_dig;
    bit          exp_upd, exp_conf;
    cap_t        c;
    if (rst_q.size() > 0 && rst_q[0] == cyc) begin
      void'(rst_q.pop_front());
      for (int i = 0; i < 4; i++) begin m_hex[i] = '0; m_cap[i] = 0; end
      m_dp = '0; m_err = '0; m_valid = '0;
    end
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && (cyc - m_cap[i]) >= TO) m_valid[i] = 1'b0;

    exp_upd = (cap_q.size() > 0 && cap_q[0].due == cyc);
    if (exp_upd || upd !== 1'b0) begin
      checks++;
      if (!exp_upd) begin
        failures++;
        $display("FAIL upd_unexpected cyc=%0d got upd=%b idx=%0d want no upd", cyc, upd, upd_idx);
      end else begin
        c = cap_q.pop_front();
        if (upd !== 1'b1 || upd_idx !== 2'(c.idx)) begin
          failures++;
          $display("FAIL upd_pulse cyc=%0d got upd=%b idx=%0d want upd=1 idx=%0d",
                   cyc, upd, upd_idx, c.idx);
        end
        m_hex[c.idx] = c.hex; m_dp[c.idx] = c.dp; m_err[c.idx] = c.bad;
        m_valid[c.idx] = 1'b1; m_cap[c.idx] = cyc;
      end
    end

    exp_conf = (conf_q.size() > 0 && conf_q[0] == cyc);
    if (exp_conf || conflict !== 1'b0) begin
      checks++;
      if (exp_conf) void'(conf_q.pop_front());
      if (conflict !== 1'(exp_conf)) begin
        failures++;
        $display("FAIL conflict cyc=%0d got %b want %b", cyc, conflict, exp_conf);
      end
    end

    exp_dig = {m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
    checks++;
    if (digits !== exp_dig || dps !== m_dp || err !== m_err || valid !== m_valid) begin
      failures++;
      $display("FAIL state cyc=%0d got dig=%h dp=%b err=%b valid=%b want dig=%h dp=%b err=%b valid=%b",
               cyc, digits, dps, err, valid, exp_dig, m_dp, m_err, m_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin m_hex[i] = '0; m_cap[i] = 0; end
    m_dp = '0; m_err = '0; m_valid = '0;
    forever begin
      @(negedge clk);
      check_cycle();
    end
  end

  initial begin
    logic [3:0] a;
    logic [7:0] sg;
    int         kind, k, len;
    rst = 1'b1; an = 4'hF; seg = 8'h00;
    model(1, 4'hF, 8'h00, 1'b1);
    repeat (2) slot(4'hF, 8'h00, 1'b1);
    hold(4'hF, 8'h00, 3);

    hold(4'b1110, 8'hDA, 12);
    hold(4'hF, 8'h00, 4);

    repeat (2) begin
      hold(4'b1110, 8'hFC, 20);
      hold(4'b1101, 8'h61, 20);
      hold(4'b1011, 8'hEE, 20);
      hold(4'b0111, 8'h8E, 20);
    end

    for (int i = 0; i < 10; i++) hold(4'b1110, (i % 2 == 0) ? 8'hFC : 8'h60, 3);
    hold(4'b1110, 8'h60, 8);
    hold(4'hF, 8'h00, 4);

    hold(4'b1100, 8'hFC, 20);
    hold(4'b1111, 8'hFC, 10);

    hold(4'b1011, 8'h00, 10);
    hold(4'b1011, 8'h66, 10);

    hold(4'b1101, 8'h30, 10);
    hold(4'hF, 8'h00, TO + 10);

    hold(4'b1101, 8'h79, 5);
    slot(4'b1101, 8'h79, 1'b1);
    hold(4'hF, 8'h00, 15);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      k = int'($urandom_range(0, 3));
      a = 4'hF;
      if (kind <= 5) a[k] = 1'b0;
      else if (kind == 7) begin a[k] = 1'b0; a[(k + 1) % 4] = 1'b0; end
      if ($urandom_range(0, 3) == 0) sg = 8'($urandom);
      else sg = HEX_BYTES[$urandom_range(0, 15)] | 8'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      if (kind == 8) slot(a, sg, 1'b1);
      else hold(a, sg, len);
    end

    hold(4'hF, 8'h00, 20);
    checks++;
    if (cap_q.size() != 0 || conf_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending_caps=%0d pending_conflicts=%0d want 0 0",
               cap_q.size(), conf_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
